date_counter: RTL and testbench
===============================

DATE_COUNTER -- requirements
Module: date_counter

Interface
REQ-001 The block SHALL have parameter START_DAY, default 1, the day-of-month loaded at reset (1..31).
REQ-002 The block SHALL have parameter START_MONTH, default 1, the month loaded at reset (1..12).
REQ-003 The block SHALL have parameter START_YEAR, default 0, the two-digit year loaded at reset (0..99, meaning 2000..2099).
REQ-004 The block SHALL have port Clock_50MHz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port day_tick, input, 1 bit: one-cycle pulse from the hour-rollover stage, meaning one day elapsed.
REQ-007 The block SHALL have port load_valid, input, 1 bit: request to load a date.
REQ-008 The block SHALL have ports load_day (5 bit), load_month (4 bit) and load_year (7 bit), all inputs: binary date to load, sampled when load_valid=1.
REQ-009 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-010 The block SHALL have ports day_ones, day_tens, mon_ones, mon_tens, yr_ones and yr_tens, all outputs, 4 bit each: BCD digits for the seven-segment decoders.
REQ-011 The block SHALL have ports month_tick, year_tick and century_tick, all outputs, 1 bit each: one-cycle rollover pulses.

Function
REQ-012 Internal state SHALL be binary day (1..31), month (1..12) and year (0..99), all registered.
REQ-013 days_in_month SHALL be 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for month 2 when year[1:0]==0; 28 for month 2 otherwise.
REQ-014 On day_tick with day < days_in_month, day SHALL increment by 1.
REQ-015 On day_tick with day == days_in_month, day SHALL become 1, month SHALL increment, and month_tick SHALL pulse.
REQ-016 On a month wrap from 12, month SHALL become 1, year SHALL increment, and year_tick SHALL pulse.
REQ-017 On a year wrap from 99, year SHALL become 0 and century_tick SHALL pulse.
REQ-018 The new date SHALL be visible in the state registers one cycle after day_tick.
REQ-019 Tick pulses SHALL assert in that same cycle and last exactly one cycle.
REQ-020 BCD outputs SHALL be registered from the state and lag it by one further cycle (total latency 2 cycles from day_tick).
REQ-021 A load SHALL be accepted only if 1<=load_month<=12, load_year<=99 and 1<=load_day<=days_in_month(load_month, load_year).
REQ-022 An accepted load SHALL replace the state on the next edge and SHALL NOT pulse any rollover tick.
REQ-023 A rejected load SHALL leave the state unchanged and SHALL pulse load_err one cycle later.
REQ-024 When load_valid and day_tick arrive in the same cycle, the load SHALL take priority, and the tick SHALL be dropped whether the load is accepted or rejected.
REQ-025 day_tick asserted on consecutive cycles SHALL advance the date once per cycle with no loss.

Reset
REQ-026 On reset, day, month and year SHALL be set to START_DAY, START_MONTH and START_YEAR.
REQ-027 On reset, the BCD outputs SHALL immediately show the start date (default 01/01/00), and all tick outputs and load_err SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard any pending tick or load.

Structure
REQ-029 A shared package date_pkg SHALL hold MAX_MONTH=12, MAX_YEAR=99, the month-length constants 28/29/30/31 and a typedef for the date struct {day, month, year}.
REQ-030 Sub-module days_in_month SHALL be combinational (month, year -> 5-bit length).
REQ-031 days_in_month SHALL be instantiated twice: once for the current date and once for load validation.
REQ-032 Binary-to-BCD conversion SHALL be by divide/modulo-10 on at most 7-bit values, with no sequential converter.

Verification
REQ-033 Reset and idle test: reset, then 3 cycles idle -> outputs read 0,1 / 0,1 / 0,0 and all ticks are 0.
REQ-034 Month rollover test: load 31/01/23, then one day_tick -> 01/02/23 with month_tick=1 for one cycle.
REQ-035 Leap-year test: from 28/02/24, two ticks -> 29/02/24 then 01/03/24; from 28/02/23, one tick -> 01/03/23.
REQ-036 Century rollover test: load 31/12/99, then one tick -> 01/01/00 with month_tick, year_tick and century_tick all pulsed in the same cycle.
REQ-037 Load-validation and priority test: load 31/04/10 -> load_err=1 and state unchanged; load 15/06/10 together with day_tick -> 15/06/10 with no advance.
REQ-038 Back-to-back and reset test: 400 consecutive day_ticks from 01/01/00 -> 04/02/01; reset asserted mid-run -> 01/01/00 asynchronously.

Source files
------------

// File: rtl/date_pkg.sv
// Shared date constants, the packed date record and the binary-to-BCD helper
// used by the calendar counter.
package date_pkg;

   localparam logic [3:0] MAX_MONTH = 4'd12;
   localparam logic [6:0] MAX_YEAR  = 7'd99;

   localparam logic [4:0] DAYS_28 = 5'd28;
   localparam logic [4:0] DAYS_29 = 5'd29;
   localparam logic [4:0] DAYS_30 = 5'd30;
   localparam logic [4:0] DAYS_31 = 5'd31;

   typedef struct packed {
      logic [4:0] day;
      logic [3:0] month;
      logic [6:0] year;
   } date_t;

   // Two-digit values only, so a plain divide/modulo stays small and combinational.
   function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
      return {4'(bin / 7'd10), 4'(bin % 7'd10)};
   endfunction

endpackage

// File: rtl/days_in_month.sv
// Month length lookup: combinational, zero latency, no flow control.
// Returns 0 for an out-of-range month so callers can treat it as invalid.
module days_in_month
   import date_pkg::*;
(
   input  logic [3:0] month_i,
   input  logic [1:0] year_lsb_i,   // only leap parity of 2000..2099 matters
   output logic [4:0] days_o
);

   always_comb begin
      days_o = 5'd0;
      case (month_i)
         4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days_o = DAYS_31;
         4'd4, 4'd6, 4'd9, 4'd11:                    days_o = DAYS_30;
         4'd2: days_o = (year_lsb_i == 2'd0) ? DAYS_29 : DAYS_28;
         default:                                    days_o = 5'd0;
      endcase
   end

endmodule

// File: rtl/date_counter.sv
// Calendar day/month/year counter with validated date load and BCD display outputs.
// State and ticks update one cycle after day_tick, BCD two cycles; no backpressure.
module date_counter
   import date_pkg::*;
#(
   parameter int START_DAY   = 1,
   parameter int START_MONTH = 1,
   parameter int START_YEAR  = 0
) (
   input  logic       Clock_50MHz,
   input  logic       reset,
   input  logic       day_tick,
   input  logic       load_valid,
   input  logic [4:0] load_day,
   input  logic [3:0] load_month,
   input  logic [6:0] load_year,
   output logic       load_err,
   output logic [3:0] day_ones,
   output logic [3:0] day_tens,
   output logic [3:0] mon_ones,
   output logic [3:0] mon_tens,
   output logic [3:0] yr_ones,
   output logic [3:0] yr_tens,
   output logic       month_tick,
   output logic       year_tick,
   output logic       century_tick
);

   localparam date_t START_DATE = '{day:   5'(START_DAY),
                                    month: 4'(START_MONTH),
                                    year:  7'(START_YEAR)};

   date_t      date_q, date_d;
   logic       month_tick_q, month_tick_d;
   logic       year_tick_q, year_tick_d;
   logic       century_tick_q, century_tick_d;
   logic       load_err_q, load_err_d;
   logic [7:0] day_bcd_q, mon_bcd_q, yr_bcd_q;

   logic [4:0] cur_dim, load_dim;
   logic       load_ok;

   days_in_month u_dim_cur (
      .month_i    (date_q.month),
      .year_lsb_i (date_q.year[1:0]),
      .days_o     (cur_dim)
   );

   days_in_month u_dim_load (
      .month_i    (load_month),
      .year_lsb_i (load_year[1:0]),
      .days_o     (load_dim)
   );

   assign load_ok = (load_month >= 4'd1) && (load_month <= MAX_MONTH) &&
                    (load_year <= MAX_YEAR) &&
                    (load_day >= 5'd1) && (load_day <= load_dim);

   // A load always wins over a coincident day_tick, which is then dropped.
   always_comb begin
      date_d         = date_q;
      month_tick_d   = 1'b0;
      year_tick_d    = 1'b0;
      century_tick_d = 1'b0;
      load_err_d     = 1'b0;
      if (load_valid) begin
         if (load_ok) begin
            date_d = '{day: load_day, month: load_month, year: load_year};
         end else begin
            load_err_d = 1'b1;
         end
      end else if (day_tick) begin
         if (date_q.day < cur_dim) begin
            date_d.day = date_q.day + 5'd1;
         end else begin
            date_d.day   = 5'd1;
            month_tick_d = 1'b1;
            if (date_q.month >= MAX_MONTH) begin
               date_d.month = 4'd1;
               year_tick_d  = 1'b1;
               if (date_q.year >= MAX_YEAR) begin
                  date_d.year    = 7'd0;
                  century_tick_d = 1'b1;
               end else begin
                  date_d.year = date_q.year + 7'd1;
               end
            end else begin
               date_d.month = date_q.month + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge Clock_50MHz or posedge reset) begin
      if (reset) begin
         date_q         <= START_DATE;
         month_tick_q   <= 1'b0;
         year_tick_q    <= 1'b0;
         century_tick_q <= 1'b0;
         load_err_q     <= 1'b0;
         day_bcd_q      <= bin2bcd({2'b00, START_DATE.day});
         mon_bcd_q      <= bin2bcd({3'b000, START_DATE.month});
         yr_bcd_q       <= bin2bcd(START_DATE.year);
      end else begin
         date_q         <= date_d;
         month_tick_q   <= month_tick_d;
         year_tick_q    <= year_tick_d;
         century_tick_q <= century_tick_d;
         load_err_q     <= load_err_d;
         day_bcd_q      <= bin2bcd({2'b00, date_q.day});
         mon_bcd_q      <= bin2bcd({3'b000, date_q.month});
         yr_bcd_q       <= bin2bcd(date_q.year);
      end
   end

   assign day_ones     = day_bcd_q[3:0];
   assign day_tens     = day_bcd_q[7:4];
   assign mon_ones     = mon_bcd_q[3:0];
   assign mon_tens     = mon_bcd_q[7:4];
   assign yr_ones      = yr_bcd_q[3:0];
   assign yr_tens      = yr_bcd_q[7:4];
   assign month_tick   = month_tick_q;
   assign year_tick    = year_tick_q;
   assign century_tick = century_tick_q;
   assign load_err     = load_err_q;

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: table of load/tick vectors with constant expectations,
// a reference-model run of back-to-back ticks, and asynchronous reset sequences.
module tb_date_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       day_tick = 1'b0;
   logic       load_valid = 1'b0;
   logic [4:0] load_day = '0;
   logic [3:0] load_month = '0;
   logic [6:0] load_year = '0;
   logic       load_err;
   logic [3:0] day_ones, day_tens, mon_ones, mon_tens, yr_ones, yr_tens;
   logic       month_tick, year_tick, century_tick;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int d, m, y;
      bit mt, yt, ct, err;
   } exp_t;

   typedef struct {
      bit   tk, lv;
      int   ld, lm, ly;
      exp_t e;
   } vec_t;

   exp_t tick_q[$];
   exp_t bcd_q[$];
   vec_t vecs[$];

   date_counter dut (
      .Clock_50MHz  (clk),
      .reset        (reset),
      .day_tick     (day_tick),
      .load_valid   (load_valid),
      .load_day     (load_day),
      .load_month   (load_month),
      .load_year    (load_year),
      .load_err     (load_err),
      .day_ones     (day_ones),
      .day_tens     (day_tens),
      .mon_ones     (mon_ones),
      .mon_tens     (mon_tens),
      .yr_ones      (yr_ones),
      .yr_tens      (yr_tens),
      .month_tick   (month_tick),
      .year_tick    (year_tick),
      .century_tick (century_tick)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic check_date(input string tag, input int d, input int m, input int y);
      check({tag, " day_ones"}, {28'd0, day_ones}, d % 10);
      check({tag, " day_tens"}, {28'd0, day_tens}, d / 10);
      check({tag, " mon_ones"}, {28'd0, mon_ones}, m % 10);
      check({tag, " mon_tens"}, {28'd0, mon_tens}, m / 10);
      check({tag, " yr_ones"},  {28'd0, yr_ones},  y % 10);
      check({tag, " yr_tens"},  {28'd0, yr_tens},  y / 10);
   endtask

   task automatic check_flags(input string tag, input bit mt, input bit yt, input bit ct, input bit er);
      check({tag, " month_tick"},   {31'd0, month_tick},   {31'd0, mt});
      check({tag, " year_tick"},    {31'd0, year_tick},    {31'd0, yt});
      check({tag, " century_tick"}, {31'd0, century_tick}, {31'd0, ct});
      check({tag, " load_err"},     {31'd0, load_err},     {31'd0, er});
   endtask

   function automatic int mlen(input int m, input int y);
      int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m < 1 || m > 12) return 0;
      if (m == 2 && (y % 4) == 0) return 29;
      return t[m-1];
   endfunction

   function automatic exp_t model(input exp_t cur, input bit tk, input bit lv,
                                  input int ld, input int lm, input int ly);
      exp_t n = cur;
      n.mt = 0; n.yt = 0; n.ct = 0; n.err = 0;
      if (lv) begin
         if (lm >= 1 && lm <= 12 && ly <= 99 && ld >= 1 && ld <= mlen(lm, ly)) begin
            n.d = ld; n.m = lm; n.y = ly;
         end else begin
            n.err = 1;
         end
      end else if (tk) begin
         if (cur.d < mlen(cur.m, cur.y)) n.d = cur.d + 1;
         else begin
            n.d = 1; n.mt = 1; n.m = cur.m + 1;
            if (n.m > 12) begin
               n.m = 1; n.yt = 1; n.y = cur.y + 1;
               if (n.y > 99) begin n.y = 0; n.ct = 1; end
            end
         end
      end
      return n;
   endfunction

   // Ticks/load_err for a driven cycle appear after its edge; BCD trails by one
   // more cycle, so the date queue is seeded with the reset date.
   task automatic step(input bit tk, input bit lv, input int ld, input int lm,
                       input int ly, input exp_t e, input string tag);
      exp_t f, b;
      day_tick   = tk;
      load_valid = lv;
      load_day   = 5'(ld);
      load_month = 4'(lm);
      load_year  = 7'(ly);
      tick_q.push_back(e);
      bcd_q.push_back(e);
      @(posedge clk);
      #1;
      f = tick_q.pop_front();
      b = bcd_q.pop_front();
      check_flags(tag, f.mt, f.yt, f.ct, f.err);
      check_date(tag, b.d, b.m, b.y);
      day_tick   = 1'b0;
      load_valid = 1'b0;
   endtask

   task automatic seed_queues();
      exp_t s = '{1, 1, 0, 0, 0, 0, 0};
      tick_q.delete();
      bcd_q.delete();
      bcd_q.push_back(s);
   endtask

   task automatic add(input bit tk, input bit lv, input int ld, input int lm, input int ly,
                      input int d, input int m, input int y,
                      input bit mt, input bit yt, input bit ct, input bit er);
      vec_t v;
      v.tk = tk; v.lv = lv; v.ld = ld; v.lm = lm; v.ly = ly;
      v.e = '{d, m, y, mt, yt, ct, er};
      vecs.push_back(v);
   endtask

   initial begin
      exp_t cur, e;

      //  tk lv  ld lm  ly    d  m  y   mt yt ct err
      add(0, 0,  0, 0,  0,    1, 1, 0,  0, 0, 0, 0);
      add(0, 0,  0, 0,  0,    1, 1, 0,  0, 0, 0, 0);
      add(0, 0,  0, 0,  0,    1, 1, 0,  0, 0, 0, 0);
      add(0, 1, 31, 1, 23,   31, 1,23,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,    1, 2,23,  1, 0, 0, 0);
      add(0, 0,  0, 0,  0,    1, 2,23,  0, 0, 0, 0);
      add(0, 1, 28, 2, 24,   28, 2,24,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,   29, 2,24,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,    1, 3,24,  1, 0, 0, 0);
      add(0, 1, 28, 2, 23,   28, 2,23,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,    1, 3,23,  1, 0, 0, 0);
      add(0, 1, 31,12, 99,   31,12,99,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,    1, 1, 0,  1, 1, 1, 0);
      add(0, 0,  0, 0,  0,    1, 1, 0,  0, 0, 0, 0);
      add(0, 1, 31, 4, 10,    1, 1, 0,  0, 0, 0, 1);
      add(0, 0,  0, 0,  0,    1, 1, 0,  0, 0, 0, 0);
      add(1, 1, 15, 6, 10,   15, 6,10,  0, 0, 0, 0);
      add(0, 0,  0, 0,  0,   15, 6,10,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,   16, 6,10,  0, 0, 0, 0);
      add(1, 1,  0, 5, 10,   16, 6,10,  0, 0, 0, 1);
      add(0, 1, 10, 0, 10,   16, 6,10,  0, 0, 0, 1);
      add(0, 1, 10,13, 10,   16, 6,10,  0, 0, 0, 1);
      add(0, 1, 10, 5,100,   16, 6,10,  0, 0, 0, 1);
      add(0, 1, 29, 2, 23,   16, 6,10,  0, 0, 0, 1);
      add(0, 1, 29, 2,  0,   29, 2, 0,  0, 0, 0, 0);
      add(0, 1, 30, 4, 10,   30, 4,10,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,    1, 5,10,  1, 0, 0, 0);
      add(0, 1, 30, 6, 10,   30, 6,10,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,    1, 7,10,  1, 0, 0, 0);
      add(0, 1, 31,12, 45,   31,12,45,  0, 0, 0, 0);
      add(1, 0,  0, 0,  0,    1, 1,46,  1, 1, 0, 0);
      add(0, 0,  0, 0,  0,    1, 1,46,  0, 0, 0, 0);

      // Power-on reset: outputs must show the start date while reset is held.
      #3 reset = 1'b1;
      #1;
      check_date("reset_hold", 1, 1, 0);
      check_flags("reset_hold", 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      seed_queues();

      foreach (vecs[i])
         step(vecs[i].tk, vecs[i].lv, vecs[i].ld, vecs[i].lm, vecs[i].ly,
              vecs[i].e, $sformatf("vec%0d", i));

      // Back-to-back ticks from the reset date, expectations from the model.
      #3 reset = 1'b1;
      #5 reset = 1'b0;
      @(posedge clk);
      #1;
      seed_queues();
      cur = '{1, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 400; i++) begin
         e = model(cur, 1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0, e, $sformatf("b2b%0d", i));
         cur = e;
      end
      e = model(cur, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, e, "b2b_idle");
      check_date("b2b_final", 4, 2, 1);

      // Reset mid-run with a tick and a valid load pending.
      for (int i = 0; i < 5; i++) begin
         e = model(cur, 1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0, e, $sformatf("pre_rst%0d", i));
         cur = e;
      end
      day_tick   = 1'b1;
      load_valid = 1'b1;
      load_day   = 5'd15;
      load_month = 4'd6;
      load_year  = 7'd10;
      #5 reset = 1'b1;
      #1;
      check_date("async_rst", 1, 1, 0);
      check_flags("async_rst", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_date("rst_held", 1, 1, 0);
      check_flags("rst_held", 0, 0, 0, 0);
      day_tick   = 1'b0;
      load_valid = 1'b0;
      #4 reset = 1'b0;
      seed_queues();
      cur = '{1, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, cur, $sformatf("post_rst%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
